// File: rtl/shift_unit_iter_pkg.sv
// Shared opcode, state and status-flag definitions for the iterative shift unit.
// Flag indices match the CVNZ layout expected by the status-register block.
package shift_unit_iter_pkg;

    localparam logic [2:0] FS_RRC  = 3'b000;
    localparam logic [2:0] FS_RRA  = 3'b001;
    localparam logic [2:0] FS_SWPB = 3'b010;
    localparam logic [2:0] FS_SXT  = 3'b011;
    localparam logic [2:0] FS_RRUM = 3'b100;
    localparam logic [2:0] FS_RLAM = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    function automatic logic is_shift_op(input logic [2:0] fs);
        return (fs == FS_RRC) || (fs == FS_RRA) || (fs == FS_RRUM) || (fs == FS_RLAM);
    endfunction

    function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                              input logic n, input logic z);
        logic [3:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/shift_unit_iter_step.sv
// One-bit shift step at byte or word width; the upper byte is zero for byte operations.
// Non-shift opcodes pass value and carry through unchanged.
module shift_unit_iter_step
    import shift_unit_iter_pkg::*;
#(
    parameter int SIZE_BYTE = 8,
    parameter int SIZE_WORD = 16
) (
    input  logic [SIZE_WORD-1:0] value,
    input  logic                 carry,
    input  logic [2:0]           fs,
    input  logic                 bw,
    output logic [SIZE_WORD-1:0] value_next,
    output logic                 carry_next,
    output logic                 sign_change
);

    localparam logic [SIZE_BYTE-1:0] ZERO_HI = '0;

    logic [SIZE_BYTE-1:0] lo;
    assign lo = value[SIZE_BYTE-1:0];

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        value_next  = value;
        carry_next  = carry;
        sign_change = 1'b0;
        if (bw) begin
            case (fs)
                FS_RRC: begin
                    value_next = {ZERO_HI, carry, lo[SIZE_BYTE-1:1]};
                    carry_next = lo[0];
                end
                FS_RRA: begin
                    value_next = {ZERO_HI, lo[SIZE_BYTE-1], lo[SIZE_BYTE-1:1]};
                    carry_next = lo[0];
                end
                FS_RRUM: begin
                    value_next = {ZERO_HI, 1'b0, lo[SIZE_BYTE-1:1]};
                    carry_next = lo[0];
                end
                FS_RLAM: begin
                    value_next  = {ZERO_HI, lo[SIZE_BYTE-2:0], 1'b0};
                    carry_next  = lo[SIZE_BYTE-1];
                    sign_change = lo[SIZE_BYTE-1] ^ lo[SIZE_BYTE-2];
                end
                default: ;
            endcase
        end else begin
            case (fs)
                FS_RRC: begin
                    value_next = {carry, value[SIZE_WORD-1:1]};
                    carry_next = value[0];
                end
                FS_RRA: begin
                    value_next = {value[SIZE_WORD-1], value[SIZE_WORD-1:1]};
                    carry_next = value[0];
                end
                FS_RRUM: begin
                    value_next = {1'b0, value[SIZE_WORD-1:1]};
                    carry_next = value[0];
                end
                FS_RLAM: begin
                    value_next  = {value[SIZE_WORD-2:0], 1'b0};
                    carry_next  = value[SIZE_WORD-1];
                    sign_change = value[SIZE_WORD-1] ^ value[SIZE_WORD-2];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/shift_unit_iter.sv
// Iterative shift/rotate unit: one bit per clock with start/busy/done handshake.
// SWPB, SXT and illegal/reserved operations complete on the load edge.
module shift_unit_iter
    import shift_unit_iter_pkg::*;
#(
    parameter int SIZE_BYTE = 8,
    parameter int SIZE_WORD = 16,
    parameter int CNT_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           FS,
    input  logic                 BW,
    input  logic                 C_IN,
    input  logic [CNT_W-1:0]     CNT,
    input  logic [SIZE_WORD-1:0] DST,
    output logic                 busy,
    output logic                 done,
    output logic [SIZE_WORD-1:0] SHIFT_OUT,
    output logic [3:0]           CVNZ_shift
);

    localparam logic [SIZE_BYTE-1:0] ZERO_HI = '0;

    state_t               state, state_next;
    logic [SIZE_WORD-1:0] val;
    logic                 carry;
    logic                 v_flag;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           fs_q;
    logic                 bw_q;
    logic [3:0]           flags;

    logic                 accept;
    logic [SIZE_WORD-1:0] step_val;
    logic                 step_carry;
    logic                 step_sign_change;
    logic                 v_next;
    logic                 n_step;
    logic                 z_step;
    logic [SIZE_WORD-1:0] sxt_val;

    assign accept = start && (state != ST_SHIFT);

    shift_unit_iter_step #(
        .SIZE_BYTE(SIZE_BYTE),
        .SIZE_WORD(SIZE_WORD)
    ) u_step (
        .value      (val),
        .carry      (carry),
        .fs         (fs_q),
        .bw         (bw_q),
        .value_next (step_val),
        .carry_next (step_carry),
        .sign_change(step_sign_change)
    );

    assign v_next  = v_flag | step_sign_change;
    assign n_step  = bw_q ? step_val[SIZE_BYTE-1] : step_val[SIZE_WORD-1];
    assign z_step  = bw_q ? (step_val[SIZE_BYTE-1:0] == '0) : (step_val == '0);
    assign sxt_val = {{SIZE_BYTE{DST[SIZE_BYTE-1]}}, DST[SIZE_BYTE-1:0]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start)                  state_next = is_shift_op(FS) ? ST_SHIFT : ST_DONE;
                else if (state == ST_DONE)  state_next = ST_IDLE;
            end
            ST_SHIFT: if (cnt == '0) state_next = ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_SHIFT);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val    <= '0;
            carry  <= 1'b0;
            v_flag <= 1'b0;
            cnt    <= '0;
            fs_q   <= FS_RRC;
            bw_q   <= 1'b0;
            flags  <= '0;
        end else if (accept) begin
            fs_q   <= FS;
            bw_q   <= BW;
            carry  <= C_IN;
            cnt    <= CNT;
            v_flag <= 1'b0;
            if (is_shift_op(FS)) begin
                val <= BW ? {ZERO_HI, DST[SIZE_BYTE-1:0]} : DST;
            end else if (FS == FS_SWPB && !BW) begin
                val   <= {DST[SIZE_BYTE-1:0], DST[SIZE_WORD-1:SIZE_BYTE]};
                flags <= '0;
            end else if (FS == FS_SXT && !BW) begin
                // Z of the extended word is Z of the low byte; C is its complement.
                val   <= sxt_val;
                flags <= pack_flags(DST[SIZE_BYTE-1:0] != '0, 1'b0, DST[SIZE_BYTE-1],
                                    DST[SIZE_BYTE-1:0] == '0);
            end else begin
                val   <= DST;
                flags <= '0;
            end
        end else if (state == ST_SHIFT) begin
            val    <= step_val;
            carry  <= step_carry;
            v_flag <= v_next;
            cnt    <= cnt - 1'b1;
            flags  <= pack_flags(step_carry, v_next, n_step, z_step);
        end
    end

    assign SHIFT_OUT  = val;
    assign CVNZ_shift = flags;

endmodule

// File: tb/tb_shift_unit_iter.sv
// Self-checking bench for shift_unit_iter: directed vectors, handshake corner cases,
// asynchronous abort and randomized operations against an arithmetic reference model.
module tb_shift_unit_iter;

    localparam int TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  FS;
    logic        BW;
    logic        C_IN;
    logic [1:0]  CNT;
    logic [15:0] DST;
    logic        busy;
    logic        done;
    logic [15:0] SHIFT_OUT;
    logic [3:0]  CVNZ_shift;

    int errors = 0;
    int checks = 0;

    shift_unit_iter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .FS        (FS),
        .BW        (BW),
        .C_IN      (C_IN),
        .CNT       (CNT),
        .DST       (DST),
        .busy      (busy),
        .done      (done),
        .SHIFT_OUT (SHIFT_OUT),
        .CVNZ_shift(CVNZ_shift)
    );

    always #5 clk = ~clk;

    // Whole-operation reference: shift amounts applied at once with integer arithmetic.
    function automatic void model(input logic [2:0] fs, input logic bw, input logic cin,
                                  input logic [1:0] cnt, input logic [15:0] dst,
                                  output logic [15:0] res, output logic [3:0] f,
                                  output int lat);
        int w, n, mask, op, x, r, t;
        logic c, v, nn, z;
        w    = bw ? 8 : 16;
        n    = int'(cnt) + 1;
        mask = (1 << w) - 1;
        op   = int'(dst) & mask;
        c    = 1'b0;
        v    = 1'b0;
        r    = 0;
        lat  = n;
        case (fs)
            3'b000: begin
                x = (int'(cin) << w) | op;
                x = ((x >> n) | (x << (w + 1 - n))) & ((1 << (w + 1)) - 1);
                r = x & mask;
                c = ((x >> w) & 1) != 0;
            end
            3'b001: begin
                x = ((op >> (w - 1)) & 1) != 0 ? op - (1 << w) : op;
                r = (x >>> n) & mask;
                c = ((op >> (n - 1)) & 1) != 0;
            end
            3'b100: begin
                r = op >> n;
                c = ((op >> (n - 1)) & 1) != 0;
            end
            3'b101: begin
                r = (op << n) & mask;
                c = ((op >> (w - n)) & 1) != 0;
                t = op >> (w - 1 - n);
                v = !(t == 0 || t == ((1 << (n + 1)) - 1));
            end
            default: lat = 0;
        endcase
        if (lat != 0) begin
            nn  = ((r >> (w - 1)) & 1) != 0;
            z   = (r == 0);
            res = 16'(r);
            f   = {c, v, nn, z};
        end else if (fs == 3'b010 && !bw) begin
            res = {dst[7:0], dst[15:8]};
            f   = 4'b0000;
        end else if (fs == 3'b011 && !bw) begin
            res = {{8{dst[7]}}, dst[7:0]};
            z   = (dst[7:0] == 8'h00);
            f   = {~z, 1'b0, dst[7], z};
        end else begin
            res = dst;
            f   = 4'b0000;
        end
    endfunction

    // Issues one operation and waits (bounded) for done; lat = edges after the sampling edge.
    task automatic do_op(input logic [2:0] fs, input logic bw, input logic cin,
                         input logic [1:0] cnt, input logic [15:0] dst,
                         output int lat, output logic [15:0] res, output logic [3:0] f,
                         output logic busy0);
        FS = fs; BW = bw; C_IN = cin; CNT = cnt; DST = dst; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy0 = busy;
        lat   = 0;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        res = SHIFT_OUT;
        f   = CVNZ_shift;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; FS = 3'b000; BW = 1'b0; C_IN = 1'b0; CNT = 2'd0; DST = 16'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (SHIFT_OUT !== 16'h0) begin errors++; $display("FAIL reset_out got=%h exp=0000", SHIFT_OUT); end
        checks++; if (CVNZ_shift !== 4'h0) begin errors++; $display("FAIL reset_cvnz got=%b exp=0000", CVNZ_shift); end
    endtask

    task automatic test_rra_steps;
        logic [15:0] steps [5] = '{16'h8010, 16'hC008, 16'hE004, 16'hF002, 16'hF801};
        FS = 3'b001; BW = 1'b0; C_IN = 1'b0; CNT = 2'd3; DST = 16'h8010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (SHIFT_OUT !== steps[i]) begin
                errors++; $display("FAIL rra_step%0d got=%h exp=%h", i, SHIFT_OUT, steps[i]);
            end
            checks++;
            if (busy !== (i < 4) || done !== (i == 4)) begin
                errors++; $display("FAIL rra_hs%0d got busy=%b done=%b", i, busy, done);
            end
            if (i < 4) begin @(posedge clk); #1; end
        end
        checks++; if (CVNZ_shift !== 4'b0010) begin errors++; $display("FAIL rra_cvnz got=%b exp=0010", CVNZ_shift); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rra_done_drop got=%b exp=0", done); end
    endtask

    typedef struct {
        string       name;
        logic [2:0]  fs;
        logic        bw;
        logic        cin;
        logic [1:0]  cnt;
        logic [15:0] dst;
        logic [15:0] res;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    task automatic test_directed;
        vec_t vecs [6] = '{
            '{"rrc_byte",  3'b000, 1'b1, 1'b1, 2'd0, 16'hAB01, 16'h0080, 4'b1010, 1},
            '{"rlam_word", 3'b101, 1'b0, 1'b0, 2'd1, 16'h4001, 16'h0004, 4'b1100, 2},
            '{"sxt_word",  3'b011, 1'b0, 1'b0, 2'd0, 16'h0080, 16'hFF80, 4'b1010, 0},
            '{"swpb_word", 3'b010, 1'b0, 1'b1, 2'd2, 16'h1234, 16'h3412, 4'b0000, 0},
            '{"sxt_byte",  3'b011, 1'b1, 1'b0, 2'd0, 16'h1280, 16'h1280, 4'b0000, 0},
            '{"reserved",  3'b111, 1'b0, 1'b1, 2'd3, 16'hBEEF, 16'hBEEF, 4'b0000, 0}
        };
        int lat;
        logic [15:0] res;
        logic [3:0]  f;
        logic        busy0;
        foreach (vecs[i]) begin
            do_op(vecs[i].fs, vecs[i].bw, vecs[i].cin, vecs[i].cnt, vecs[i].dst, lat, res, f, busy0);
            checks++;
            if (lat != vecs[i].lat || res !== vecs[i].res || f !== vecs[i].f) begin
                errors++;
                $display("FAIL %s got lat=%0d out=%h cvnz=%b exp lat=%0d out=%h cvnz=%b",
                         vecs[i].name, lat, res, f, vecs[i].lat, vecs[i].res, vecs[i].f);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL %s_done_drop got=%b exp=0", vecs[i].name, done); end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [15:0] res, eres;
        logic [3:0]  f, ef;
        logic        busy0;
        int          elat;
        FS = 3'b100; BW = 1'b0; C_IN = 1'b0; CNT = 2'd3; DST = 16'h000F; start = 1'b1;
        @(posedge clk); #1;
        FS = 3'b101; DST = 16'hFFFF; CNT = 2'd0; C_IN = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < TIMEOUT) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != 4 || SHIFT_OUT !== 16'h0000 || CVNZ_shift !== 4'b1001) begin
            errors++;
            $display("FAIL rrum_ignore got lat=%0d out=%h cvnz=%b exp lat=4 out=0000 cvnz=1001",
                     lat, SHIFT_OUT, CVNZ_shift);
        end
        model(3'b001, 1'b1, 1'b0, 2'd1, 16'h0081, eres, ef, elat);
        do_op(3'b001, 1'b1, 1'b0, 2'd1, 16'h0081, lat, res, f, busy0);
        checks++;
        if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b exp=1", busy0); end
        checks++;
        if (lat != elat || res !== eres || f !== ef) begin
            errors++;
            $display("FAIL b2b_op got lat=%0d out=%h cvnz=%b exp lat=%0d out=%h cvnz=%b",
                     lat, res, f, elat, eres, ef);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort;
        int seen;
        FS = 3'b001; BW = 1'b0; C_IN = 1'b0; CNT = 2'd3; DST = 16'h8010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || SHIFT_OUT !== 16'h0 || CVNZ_shift !== 4'h0) begin
            errors++;
            $display("FAIL abort_clear got busy=%b done=%b out=%h cvnz=%b exp all zero",
                     busy, done, SHIFT_OUT, CVNZ_shift);
        end
        #2 rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    endtask

    task automatic test_random;
        logic [2:0]  fs;
        logic        bw, cin, busy0;
        logic [1:0]  cnt;
        logic [15:0] dst, res, eres;
        logic [3:0]  f, ef;
        int          lat, elat;
        for (int i = 0; i < 40; i++) begin
            fs  = 3'($urandom_range(0, 7));
            bw  = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            cnt = 2'($urandom_range(0, 3));
            dst = 16'($urandom);
            model(fs, bw, cin, cnt, dst, eres, ef, elat);
            do_op(fs, bw, cin, cnt, dst, lat, res, f, busy0);
            checks++;
            if (lat != elat || res !== eres || f !== ef || busy0 !== (elat != 0)) begin
                errors++;
                $display("FAIL rand%0d fs=%b bw=%b cin=%b cnt=%0d dst=%h got lat=%0d out=%h cvnz=%b busy=%b exp lat=%0d out=%h cvnz=%b",
                         i, fs, bw, cin, cnt, dst, lat, res, f, busy0, elat, eres, ef);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_rra_steps();
        test_directed();
        test_back_to_back();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
